// File: rtl/uart_param_txrx.sv
// Parametrised full-duplex UART: configurable width, parity and stop bits, synchronised RX
// with a mid-bit start filter, parity/framing error flags and a busy/done TX handshake.
module uart_param_txrx #(
    parameter int CLK_FREQ  = 100000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int STOP_LEN = STOP_BITS * BAUD_DIV;
    localparam int CW       = $clog2(STOP_LEN + 1);
    localparam int BW       = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] DIV_END  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 2);
    localparam logic [BW-1:0] BIT_END  = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY == 1);

    if (BAUD_DIV < 4) begin : g_bad_div
        $error("uart_param_txrx: CLK_FREQ/BAUD must be >= 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_param_txrx: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_par
        $error("uart_param_txrx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_param_txrx: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_state_t;
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_BREAK} rx_state_t;

    tx_state_t            t_st;
    logic [CW-1:0]        t_cnt;
    logic [BW-1:0]        t_bit;
    logic [DATA_BITS-1:0] t_sh;
    logic                 t_par;

    // The last stop cycle is spent in IDLE with done/ready up, so a start request
    // seen there follows the stop bit with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_st    <= T_IDLE;
            t_cnt   <= '0;
            t_bit   <= '0;
            t_sh    <= '0;
            t_par   <= 1'b0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (t_st)
                T_IDLE: begin
                    if (tx_start) begin
                        t_sh    <= tx_data;
                        t_par   <= ^tx_data ^ ODD;
                        t_cnt   <= '0;
                        t_st    <= T_START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                T_START: begin
                    if (t_cnt == DIV_END) begin
                        t_cnt <= '0;
                        t_bit <= '0;
                        tx    <= t_sh[0];
                        t_sh  <= t_sh >> 1;
                        t_st  <= T_DATA;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                T_DATA: begin
                    if (t_cnt == DIV_END) begin
                        t_cnt <= '0;
                        if (t_bit == BIT_END) begin
                            if (PARITY != 0) begin
                                t_st <= T_PAR;
                                tx   <= t_par;
                            end else begin
                                t_st <= T_STOP;
                                tx   <= 1'b1;
                            end
                        end else begin
                            t_bit <= t_bit + 1'b1;
                            tx    <= t_sh[0];
                            t_sh  <= t_sh >> 1;
                        end
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                T_PAR: begin
                    if (t_cnt == DIV_END) begin
                        t_cnt <= '0;
                        t_st  <= T_STOP;
                        tx    <= 1'b1;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                T_STOP: begin
                    if (t_cnt == STOP_END) begin
                        t_st    <= T_IDLE;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end else begin
                        t_cnt <= t_cnt + 1'b1;
                    end
                end
                default: t_st <= T_IDLE;
            endcase
        end
    end

    logic [1:0] sync;
    logic       rx_s;
    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end

    rx_state_t            r_st;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_sh;
    logic                 r_par;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st          <= R_IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_sh          <= '0;
            r_par         <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (r_st)
                R_IDLE: begin
                    if (!rx_s) begin
                        r_cnt <= '0;
                        r_st  <= R_START;
                    end
                end
                // Re-check the start bit half a bit in; anything shorter is a glitch.
                R_START: begin
                    if (r_cnt == HALF_END) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                        r_st  <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (r_cnt == DIV_END) begin
                        r_cnt <= '0;
                        r_sh  <= {rx_s, r_sh[DATA_BITS-1:1]};
                        if (r_bit == BIT_END) r_st <= (PARITY != 0) ? R_PAR : R_STOP;
                        else                  r_bit <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_PAR: begin
                    if (r_cnt == DIV_END) begin
                        r_cnt <= '0;
                        r_par <= rx_s;
                        r_st  <= R_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (r_cnt == DIV_END) begin
                        r_cnt         <= '0;
                        rx_valid      <= 1'b1;
                        rx_data       <= r_sh;
                        rx_parity_err <= (PARITY != 0) && ((^{r_sh, r_par}) != ODD);
                        rx_frame_err  <= ~rx_s;
                        r_st          <= rx_s ? R_IDLE : R_BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                R_BREAK: begin
                    if (rx_s) r_st <= R_IDLE;
                end
                default: r_st <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_param_txrx.sv
// Bench for uart_param_txrx: three configurations (8N1 with loopback, 8E1, 8O2), vector
// table plus hand-written glitch, break, back-to-back and reset sequences.
module tb_uart_param_txrx;
    localparam int DIV = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [2:0] tx_start, tx_o, tx_busy, tx_done, rx_drv, rx_valid, perr, ferr;
    logic [7:0] tx_data [3];
    logic [7:0] rx_data [3];
    logic       loop0, rx0_line;
    assign rx0_line = loop0 ? tx_o[0] : rx_drv[0];

    uart_param_txrx #(.CLK_FREQ(100000), .BAUD(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start[0]), .tx_data(tx_data[0]), .tx(tx_o[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .rx(rx0_line), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]));
    uart_param_txrx #(.CLK_FREQ(100000), .BAUD(9600), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start[1]), .tx_data(tx_data[1]), .tx(tx_o[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .rx(rx_drv[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]));
    uart_param_txrx #(.CLK_FREQ(100000), .BAUD(9600), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start[2]), .tx_data(tx_data[2]), .tx(tx_o[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .rx(rx_drv[2]), .rx_data(rx_data[2]),
        .rx_valid(rx_valid[2]), .rx_parity_err(perr[2]), .rx_frame_err(ferr[2]));

    typedef struct packed {logic [7:0] d; logic pe; logic fe;} exp_t;
    typedef struct {int w; logic [7:0] d; logic flip; logic stopv; logic pe; logic fe;} vec_t;

    exp_t q0[$], q1[$], q2[$];
    exp_t last [3];
    int   total = 0, bad = 0;
    int   vcnt [3] = '{0, 0, 0};
    int   dcnt [3] = '{0, 0, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input int w, input exp_t e);
        if (w == 0)      q0.push_back(e);
        else if (w == 1) q1.push_back(e);
        else             q2.push_back(e);
    endtask

    // Scoreboard: every rx_valid must match the oldest expected frame of that port.
    always @(posedge clk) begin
        #1;
        for (int w = 0; w < 3; w++) begin
            if (tx_done[w]) dcnt[w]++;
            if (rx_valid[w]) begin
                exp_t e;
                logic got;
                got = 1'b0;
                e   = '0;
                vcnt[w]++;
                if (w == 0 && q0.size() > 0)      begin e = q0.pop_front(); got = 1'b1; end
                else if (w == 1 && q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                else if (w == 2 && q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
                chk("rx_expected", got, 1);
                if (got) begin
                    chk("rx_data", rx_data[w], e.d);
                    chk("rx_parity_err", perr[w], e.pe);
                    chk("rx_frame_err", ferr[w], e.fe);
                    last[w] = e;
                end
            end
        end
    end

    function automatic int par_of(input int w);
        return (w == 1) ? 2 : (w == 2) ? 1 : 0;
    endfunction

    function automatic int flen(input int w);
        return 9 + ((par_of(w) != 0) ? 1 : 0) + ((w == 2) ? 2 : 1);
    endfunction

    // Line bits of one frame, index 0 = start bit; unused tail stays high.
    function automatic logic [11:0] fbits(input int w, input logic [7:0] d, input logic flip,
                                          input logic stopv);
        logic [11:0] b;
        int i;
        b    = '1;
        b[0] = 1'b0;
        for (int k = 0; k < 8; k++) b[1+k] = d[k];
        i = 9;
        if (par_of(w) != 0) begin
            b[9] = ((par_of(w) == 2) ? (^d) : ~(^d)) ^ flip;
            i = 10;
        end
        b[i] = stopv;
        return b;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input int w, input logic [11:0] b, input int len);
        for (int k = 0; k < len; k++) begin
            rx_drv[w] = b[k];
            wait_cyc(DIV);
        end
        rx_drv[w] = 1'b1;
    endtask

    // Sends one frame and checks every bit at mid-bit; the done cycle is the last stop cycle.
    task automatic send_tx(input int w, input logic [7:0] d);
        logic [11:0] b;
        int len;
        logic early;
        b     = fbits(w, d, 1'b0, 1'b1);
        len   = flen(w);
        early = 1'b0;
        chk("tx_ready", tx_busy[w], 0);
        tx_start[w] = 1'b1;
        tx_data[w]  = d;
        wait_cyc(1);
        tx_start[w] = 1'b0;
        chk("tx_busy", tx_busy[w], 1);
        for (int c = 1; c <= len * DIV; c++) begin
            if (c > 1) wait_cyc(1);
            if ((c - 1) % DIV == 5) chk("tx_bit", tx_o[w], b[(c-1)/DIV]);
            if (c < len * DIV && tx_done[w]) early = 1'b1;
        end
        chk("tx_done_early", early, 0);
        chk("tx_done", tx_done[w], 1);
        chk("tx_busy_at_done", tx_busy[w], 0);
    endtask

    vec_t        vt [12];
    int          v0, d0, errs, derrs;
    logic [11:0] bb;

    initial begin
        vt[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[1]  = '{0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{1, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[6]  = '{1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{2, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{2, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[10] = '{2, 8'h7E, 1'b1, 1'b1, 1'b1, 1'b0};
        vt[11] = '{2, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n    = 1'b0;
        tx_start = '0;
        rx_drv   = '1;
        loop0    = 1'b1;
        for (int w = 0; w < 3; w++) tx_data[w] = 8'h00;
        wait_cyc(3);
        chk("rst_tx", tx_o, 3'b111);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_rx_data", rx_data[0], 0);
        chk("rst_flags", {perr, ferr}, 0);
        rst_n = 1'b1;
        wait_cyc(5);

        for (int i = 0; i < 12; i++) begin
            push(vt[i].w, '{vt[i].d, vt[i].pe, vt[i].fe});
            if (vt[i].w == 0) send_tx(0, vt[i].d);
            else drive_rx(vt[i].w, fbits(vt[i].w, vt[i].d, vt[i].flip, vt[i].stopv), flen(vt[i].w));
            wait_cyc(20);
        end

        // Parity bit on the line, with TX and RX of the same port active at once.
        push(1, '{8'h5A, 1'b0, 1'b0});
        fork
            send_tx(1, 8'hA5);
            drive_rx(1, fbits(1, 8'h5A, 1'b0, 1'b1), flen(1));
        join
        wait_cyc(20);
        send_tx(2, 8'hA5);
        wait_cyc(20);

        // Short low glitch: no frame, flags untouched, receiver still usable.
        loop0 = 1'b0;
        v0 = vcnt[0];
        rx_drv[0] = 1'b0;
        wait_cyc(3);
        rx_drv[0] = 1'b1;
        wait_cyc(40);
        chk("glitch_no_valid", vcnt[0] - v0, 0);
        chk("glitch_data", rx_data[0], last[0].d);
        chk("glitch_flags", {perr[0], ferr[0]}, {last[0].pe, last[0].fe});
        push(0, '{8'h96, 1'b0, 1'b0});
        drive_rx(0, fbits(0, 8'h96, 1'b0, 1'b1), 10);
        wait_cyc(20);

        // Line held low: one framing-error frame, then recovery.
        v0 = vcnt[0];
        push(0, '{8'h00, 1'b0, 1'b1});
        rx_drv[0] = 1'b0;
        wait_cyc(300);
        rx_drv[0] = 1'b1;
        wait_cyc(30);
        chk("break_one_valid", vcnt[0] - v0, 1);
        push(0, '{8'h3C, 1'b0, 1'b0});
        drive_rx(0, fbits(0, 8'h3C, 1'b0, 1'b1), 10);
        wait_cyc(20);

        // tx_start held: frames accepted in each done cycle, stop bit runs straight into start.
        loop0 = 1'b1;
        wait_cyc(5);
        for (int i = 0; i < 3; i++) push(0, '{8'h5A, 1'b0, 1'b0});
        d0    = dcnt[0];
        errs  = 0;
        derrs = 0;
        bb    = fbits(0, 8'h5A, 1'b0, 1'b1);
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'h5A;
        for (int c = 1; c <= 250; c++) begin
            wait_cyc(1);
            if (c <= 200 && tx_o[0] !== bb[((c-1)%100)/10]) errs++;
            if (tx_done[0] !== ((c == 100) || (c == 200))) derrs++;
        end
        tx_start[0] = 1'b0;
        wait_cyc(80);
        chk("b2b_tx_stream", errs, 0);
        chk("b2b_done_timing", derrs, 0);
        chk("b2b_frames", dcnt[0] - d0, 3);

        // Start request mid-frame must not disturb the frame in flight.
        push(0, '{8'hC3, 1'b0, 1'b0});
        fork
            send_tx(0, 8'hC3);
            begin
                wait_cyc(35);
                tx_start[0] = 1'b1;
                tx_data[0]  = 8'hFF;
                wait_cyc(1);
                tx_start[0] = 1'b0;
            end
        join
        wait_cyc(20);
        chk("ignore_idle", tx_busy[0], 0);

        // Reset mid TX and mid RX (loopback), then a clean frame.
        d0 = dcnt[0];
        v0 = vcnt[0];
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'hA5;
        wait_cyc(1);
        tx_start[0] = 1'b0;
        wait_cyc(45);
        rst_n = 1'b0;
        #1;
        chk("midrst_tx", tx_o[0], 1);
        chk("midrst_busy", tx_busy[0], 0);
        chk("midrst_rx_data", rx_data[0], 0);
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(100);
        chk("midrst_no_done", dcnt[0] - d0, 0);
        chk("midrst_no_valid", vcnt[0] - v0, 0);
        push(0, '{8'h3C, 1'b0, 1'b0});
        send_tx(0, 8'h3C);
        wait_cyc(20);

        for (int i = 0; i < 2000 && (q0.size() + q1.size() + q2.size()) != 0; i++) wait_cyc(1);
        chk("scoreboard_drain", q0.size() + q1.size() + q2.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
